adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 2..64.
REQ-002 clk  input  1  single clock; all registered state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input1  input  WIDTH  first addend, unsigned or two's complement.
REQ-005 input2  input  WIDTH  second addend, unsigned or two's complement.
REQ-006 clr_sticky  input  1  synchronous clear of the sticky flags.
REQ-007 out  output  WIDTH  combinational sum.
REQ-008 sum_q  output  WIDTH  registered copy of out.
REQ-009 carry_q  output  1  registered unsigned carry-out.
REQ-010 ovf_q  output  1  registered signed-overflow flag.
REQ-011 carry_sticky  output  1  set when any carry has been registered since the last clear.
REQ-012 ovf_sticky  output  1  set when any overflow has been registered since the last clear.

Function
REQ-013 out SHALL equal (input1 + input2) mod 2^WIDTH, with zero latency, independent of clk and rst.
REQ-014 out SHALL settle within the same delta/timestep as any input change; no register is permitted on this path.
REQ-015 Each rising clk edge with rst low SHALL load sum_q <= out.
REQ-016 On the same edge, carry_q SHALL load bit WIDTH of the (WIDTH+1)-bit zero-extended sum.
REQ-017 On the same edge, ovf_q SHALL load 1 when both operand MSBs are equal and the sum MSB differs from them, else 0.
REQ-018 The registered outputs (sum_q, carry_q, ovf_q) SHALL have one-cycle latency and no handshake; a new result is registered every cycle.
REQ-019 carry_sticky SHALL be set on the edge that registers carry 1, and SHALL hold until rst or clr_sticky.
REQ-020 ovf_sticky SHALL behave the same way for overflow.
REQ-021 If clr_sticky and a new carry or overflow event occur on the same edge, the set SHALL win and the flag reads 1.
REQ-022 Wrap-around: an all-ones operand plus 1 SHALL give out 0 and carry 1; no saturation.

Reset
REQ-023 When rst is high at a rising edge, sum_q, carry_q, ovf_q, carry_sticky and ovf_sticky SHALL all become 0, overriding all other updates.
REQ-024 rst SHALL NOT affect out; the combinational sum stays valid during reset.
REQ-025 Deasserting rst mid-stream SHALL resume normal registration on the first edge with rst low, with no residual state.

Configuration
REQ-026 Macro ADDER_STATUS_EN, when defined, SHALL compile in carry_q, ovf_q, carry_sticky, ovf_sticky and their logic.
REQ-027 When ADDER_STATUS_EN is undefined:
- those four outputs SHALL be tied constant 0;
- clr_sticky SHALL be ignored;
- out and sum_q SHALL be unchanged.

Verification
REQ-028 Random inputs: 10 vectors with input1, input2 uniformly in 0..9, 10 ns apart -> out == input1 + input2 each time; zero errors reported.
REQ-029 input1=3, input2=4 -> out=7 immediately; sum_q=7 after the next edge; carry_q=0; ovf_q=0.
REQ-030 Unsigned wrap: input1=0xFFFFFFFF, input2=1 -> out=0; after the next edge, carry_q=1, ovf_q=0, carry_sticky=1 (ADDER_STATUS_EN defined).
REQ-031 Signed overflow: input1=0x7FFFFFFF, input2=1 -> out=0x80000000; after the next edge, ovf_q=1, carry_q=0; ovf_sticky stays 1 after the inputs return to 0 until clr_sticky is pulsed.
REQ-032 Reset: with the sticky flags set, pulse rst for one edge while input1=5, input2=6 -> out=11 throughout; all registered outputs 0 after the edge; sum_q=11 on the following edge.
REQ-033 Macro off: build without ADDER_STATUS_EN and repeat REQ-030 -> out=0, sum_q=0; all status outputs remain 0.

Source files
------------

// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the adder; parameter WIDTH sets the operand/result width.
// Signals: input1, input2, clr_sticky (driven by master); out, sum_q, carry_q, ovf_q,
// carry_sticky, ovf_sticky (driven by the adder through the slave modport).
interface adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             clr_sticky;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             carry_sticky;
    logic             ovf_sticky;

    modport master (
        output input1, input2, clr_sticky,
        input  out, sum_q, carry_q, ovf_q, carry_sticky, ovf_sticky
    );

    modport slave (
        input  input1, input2, clr_sticky,
        output out, sum_q, carry_q, ovf_q, carry_sticky, ovf_sticky
    );
endinterface

// File: rtl/adder.sv
// adder: combinational WIDTH-bit adder with registered sum and optional carry/overflow status.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
//        bus (adder_if.slave): input1/input2 addends, clr_sticky clears sticky flags,
//        out combinational sum, sum_q registered sum, carry_q/ovf_q registered flags,
//        carry_sticky/ovf_sticky accumulated flags.
// Macro ADDER_STATUS_EN: when defined, builds the carry/overflow status logic;
// otherwise the four status outputs are tied to 0 and clr_sticky is ignored.
module adder #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    adder_if.slave bus
);
    logic [WIDTH-1:0] sum_d, sum_q;

    assign bus.sum_q = sum_q;

`ifdef ADDER_STATUS_EN
    logic [WIDTH:0] sum_ext;
    logic carry_d, carry_q, ovf_d, ovf_q;
    logic carry_sticky_d, carry_sticky_q, ovf_sticky_d, ovf_sticky_q;

    assign sum_ext = {1'b0, bus.input1} + {1'b0, bus.input2};
    assign bus.out = sum_ext[WIDTH-1:0];

    always_comb begin
        sum_d   = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
        // Overflow: operands share a sign and the result sign differs from it.
        ovf_d   = (bus.input1[WIDTH-1] == bus.input2[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != bus.input1[WIDTH-1]);
        // A new event wins over a simultaneous clear.
        carry_sticky_d = carry_d | (carry_sticky_q & ~bus.clr_sticky);
        ovf_sticky_d   = ovf_d   | (ovf_sticky_q   & ~bus.clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q          <= '0;
            carry_q        <= 1'b0;
            ovf_q          <= 1'b0;
            carry_sticky_q <= 1'b0;
            ovf_sticky_q   <= 1'b0;
        end else begin
            sum_q          <= sum_d;
            carry_q        <= carry_d;
            ovf_q          <= ovf_d;
            carry_sticky_q <= carry_sticky_d;
            ovf_sticky_q   <= ovf_sticky_d;
        end
    end

    assign bus.carry_q      = carry_q;
    assign bus.ovf_q        = ovf_q;
    assign bus.carry_sticky = carry_sticky_q;
    assign bus.ovf_sticky   = ovf_sticky_q;
`else
    assign bus.out = bus.input1 + bus.input2;
    assign sum_d   = bus.out;

    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign bus.carry_q      = 1'b0;
    assign bus.ovf_q        = 1'b0;
    assign bus.carry_sticky = 1'b0;
    assign bus.ovf_sticky   = 1'b0;
`endif
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder; status expectations follow ADDER_STATUS_EN.
module tb_adder;
    localparam int W = 32;
`ifdef ADDER_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         cs;
        logic         os;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic m_cs = 1'b0;
    logic m_os = 1'b0;

    always #5 clk = ~clk;

    adder_if #(.WIDTH(W)) bus ();
    adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr, input logic r);
        logic [W:0] s;
        logic c, o;
        exp_t e;
        @(negedge clk);
        bus.input1 = a;
        bus.input2 = b;
        bus.clr_sticky = clr;
        rst = r;
        #1;
        s = {1'b0, a} + {1'b0, b};
        check("out", {32'd0, bus.out}, {32'd0, s[W-1:0]});
        c = STAT & s[W];
        o = STAT & (a[W-1] == b[W-1]) & (s[W-1] != a[W-1]);
        m_cs = r ? 1'b0 : (c | (m_cs & ~clr));
        m_os = r ? 1'b0 : (o | (m_os & ~clr));
        e.sum = r ? '0 : s[W-1:0];
        e.c   = r ? 1'b0 : c;
        e.o   = r ? 1'b0 : o;
        e.cs  = m_cs;
        e.os  = m_os;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("sum_q", {32'd0, bus.sum_q}, {32'd0, e.sum});
            check("carry_q", {63'd0, bus.carry_q}, {63'd0, e.c});
            check("ovf_q", {63'd0, bus.ovf_q}, {63'd0, e.o});
            check("carry_sticky", {63'd0, bus.carry_sticky}, {63'd0, e.cs});
            check("ovf_sticky", {63'd0, bus.ovf_sticky}, {63'd0, e.os});
        end
    endtask

    initial begin
        bus.input1 = '0;
        bus.input2 = '0;
        bus.clr_sticky = 1'b0;
        step(32'd0, 32'd0, 1'b0, 1'b1);
        step(32'd9, 32'd9, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step(32'($urandom_range(9)), 32'($urandom_range(9)), 1'b0, 1'b0);
        step(32'd3, 32'd4, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step(32'd5, 32'd6, 1'b0, 1'b1);
        step(32'd5, 32'd6, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
